// File: rtl/rca_result_collector_pkg.sv
// Shared definitions for the RCA result collector: FSM encoding, default
// half-word width and a constant clog2 helper for sizing pointers/counters.
package rca_result_collector_pkg;

  localparam int HALF_W_DEFAULT = 16;

  // Which half of a 32-bit add the collector expects next.
  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } state_t;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rca_result_collector_if.sv
// Bundles the collector's upstream half-word stream, downstream result
// handshake and status outputs. The collector uses the slave modport; the
// environment driving it uses the master modport.
interface rca_result_collector_if
  import rca_result_collector_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEFAULT,
  parameter int DEPTH  = 2
) ();

  localparam int CW = clog2(DEPTH) + 1;

  logic [HALF_W-1:0]   S_IN;
  logic                C_IN;
  logic                IN_VALID;
  logic                IN_READY;
  logic                RESYNC;
  logic [2*HALF_W-1:0] RESULT;
  logic                C_OUT;
  logic                OUT_VALID;
  logic                OUT_READY;
  logic                ERR_DROP;
  logic [CW-1:0]       COUNT;

  modport master (
    output S_IN, C_IN, IN_VALID, RESYNC, OUT_READY,
    input  IN_READY, RESULT, C_OUT, OUT_VALID, ERR_DROP, COUNT
  );

  modport slave (
    input  S_IN, C_IN, IN_VALID, RESYNC, OUT_READY,
    output IN_READY, RESULT, C_OUT, OUT_VALID, ERR_DROP, COUNT
  );

endinterface

// File: rtl/rca_result_fifo.sv
// Small synchronous FIFO holding assembled results. The head entry is read
// straight from storage, so dout is stable until a pop. The caller
// guarantees push is only asserted when there is room (or a same-cycle pop).
module rca_result_fifo
  import rca_result_collector_pkg::*;
#(
  parameter  int W     = 33,
  parameter  int DEPTH = 2,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  // Storage write; the array is cleared so the head reads zero after reset.
  // NOTE: memories are normally left unreset; this one is tiny and the head
  // must present a defined zero result out of reset, so it is cleared here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks fill.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/rca_result_collector.sv
// Reassembles low/high sum half-words from the RCA wrapper into full-width
// results with carry, buffers them in a FIFO and hands them downstream on a
// valid/ready handshake. RESYNC realigns the half-word phase and flags any
// low half it throws away.
module rca_result_collector
  import rca_result_collector_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEFAULT,
  parameter int DEPTH  = 2
) (
  input  logic               CLK,
  input  logic               RST,
  rca_result_collector_if.slave bus
);

  localparam int            CW      = clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [HALF_W-1:0]   low_hold;
  logic                err_drop;
  logic                in_ready;
  logic                xfer;
  logic                push;
  logic                pop;
  logic [CW-1:0]       count;
  logic [2*HALF_W:0]   head;

  assign pop = (count != '0) && bus.OUT_READY;

  // Handshake and phase decode: who may transfer and where the FSM goes.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    xfer      = 1'b0;
    push      = 1'b0;

    unique case (state)
      ST_LO: in_ready = 1'b1;
      ST_HI: in_ready = (count < DEPTH_C) || pop;
    endcase
    if (bus.RESYNC) in_ready = 1'b0;

    xfer = bus.IN_VALID && in_ready;
    push = xfer && (state == ST_HI);

    if (bus.RESYNC) begin
      state_nxt = ST_LO;
    end else if (xfer) begin
      state_nxt = (state == ST_LO) ? ST_HI : ST_LO;
    end
  end

  // Phase register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_LO;
    else     state <= state_nxt;
  end

  // Capture the low half while waiting for its partner.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                        low_hold <= '0;
    else if (xfer && state == ST_LO) low_hold <= bus.S_IN;
  end

  // Sticky flag: a held low half was thrown away by RESYNC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            err_drop <= 1'b0;
    else if (bus.RESYNC && state == ST_HI) err_drop <= 1'b1;
  end

  rca_result_fifo #(
    .W     (2*HALF_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .din   ({bus.C_IN, bus.S_IN, low_hold}),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign bus.IN_READY  = in_ready;
  assign bus.RESULT    = head[2*HALF_W-1:0];
  assign bus.C_OUT     = head[2*HALF_W];
  assign bus.OUT_VALID = (count != '0);
  assign bus.ERR_DROP  = err_drop;
  assign bus.COUNT     = count;

endmodule

// File: tb/tb_rca_result_collector.sv
// Directed bench for rca_result_collector (HALF_W=16, DEPTH=2): a table of
// per-cycle vectors for the basic flow, then hand-written sequences for
// backpressure, full push/pop, RESYNC, async reset and pointer wrap.
module tb_rca_result_collector;

  logic CLK;
  logic RST;
  int   n_vec;
  int   n_fail;

  rca_result_collector_if #(.HALF_W(16), .DEPTH(2)) bus ();

  rca_result_collector #(.HALF_W(16), .DEPTH(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        iv;
    logic [15:0] s;
    logic        c;
    logic        rs;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_res;
    logic        e_c;
    logic        e_err;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one half-word; caller is just after a rising edge. Bounded wait.
  task automatic send_half(input logic [15:0] s, input logic c);
    logic ok;
    ok = 1'b0;
    bus.S_IN     = s;
    bus.C_IN     = c;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge CLK);
      ok = bus.IN_READY;
      @(posedge CLK);
      #1;
    end
    bus.IN_VALID = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    RST           = 1'b1;
    bus.S_IN      = '0;
    bus.C_IN      = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.RESYNC    = 1'b0;
    bus.OUT_READY = 1'b0;

    //              iv  s        c     rs    or  | ir  ov  result          c     err   cnt
    vecs[0] = '{1'b1, 16'h5678, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 2'd1};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0};
    vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0};
    vecs[5] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0};
    vecs[6] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00020001, 1'b0, 1'b0, 2'd1};
    vecs[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00020001, 1'b0, 1'b0, 2'd1};
    vecs[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0};

    // Reset state.
    #3;
    check("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    check("rst_count",     64'(bus.COUNT),     64'd0);
    check("rst_result",    64'(bus.RESULT),    64'd0);
    check("rst_c_out",     64'(bus.C_OUT),     64'd0);
    check("rst_err_drop",  64'(bus.ERR_DROP),  64'd0);
    #9;
    RST = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.IN_READY), 64'd1);
    step();

    // Table-driven per-cycle vectors: expectations are pre-edge values.
    for (int i = 0; i < 10; i++) begin
      bus.IN_VALID  = vecs[i].iv;
      bus.S_IN      = vecs[i].s;
      bus.C_IN      = vecs[i].c;
      bus.RESYNC    = vecs[i].rs;
      bus.OUT_READY = vecs[i].ordy;
      @(negedge CLK);
      check($sformatf("v%0d_in_ready", i),  64'(bus.IN_READY),  64'(vecs[i].e_ir));
      check($sformatf("v%0d_out_valid", i), 64'(bus.OUT_VALID), 64'(vecs[i].e_ov));
      check($sformatf("v%0d_err_drop", i),  64'(bus.ERR_DROP),  64'(vecs[i].e_err));
      check($sformatf("v%0d_count", i),     64'(bus.COUNT),     64'(vecs[i].e_cnt));
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_result", i), 64'(bus.RESULT), 64'(vecs[i].e_res));
        check($sformatf("v%0d_c_out", i),  64'(bus.C_OUT),  64'(vecs[i].e_c));
      end
      step();
    end
    bus.IN_VALID = 1'b0;
    bus.RESYNC   = 1'b0;

    // Backpressure with DEPTH=2, then simultaneous push/pop while full.
    bus.OUT_READY = 1'b0;
    send_half(16'h1111, 1'b0);
    send_half(16'h2222, 1'b0);
    send_half(16'h3333, 1'b0);
    send_half(16'h4444, 1'b1);
    send_half(16'h5555, 1'b0);
    bus.S_IN     = 16'h6666;
    bus.C_IN     = 1'b0;
    bus.IN_VALID = 1'b1;
    @(negedge CLK);
    check("bp_count_full", 64'(bus.COUNT),    64'd2);
    check("bp_in_ready_0", 64'(bus.IN_READY), 64'd0);
    step();
    check("bp_high_held", 64'(bus.COUNT), 64'd2);
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp_in_ready_1", 64'(bus.IN_READY), 64'd1);
    check("bp_res_a",      64'(bus.RESULT),   64'h22221111);
    check("bp_c_a",        64'(bus.C_OUT),    64'd0);
    step();
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    check("bp_pushpop_count", 64'(bus.COUNT),  64'd2);
    check("bp_res_b",         64'(bus.RESULT), 64'h44443333);
    check("bp_c_b",           64'(bus.C_OUT),  64'd1);
    step();
    @(negedge CLK);
    check("bp_count_1", 64'(bus.COUNT),  64'd1);
    check("bp_res_c",   64'(bus.RESULT), 64'h66665555);
    check("bp_c_c",     64'(bus.C_OUT),  64'd0);
    step();
    @(negedge CLK);
    check("bp_drained", 64'(bus.OUT_VALID), 64'd0);
    step();

    // RESYNC while holding a low half.
    send_half(16'hAAAA, 1'b0);
    bus.RESYNC   = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.S_IN     = 16'hBBBB;
    @(negedge CLK);
    check("rs_in_ready", 64'(bus.IN_READY), 64'd0);
    step();
    bus.RESYNC   = 1'b0;
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    check("rs_err_drop", 64'(bus.ERR_DROP), 64'd1);
    check("rs_no_push",  64'(bus.COUNT),    64'd0);
    step();
    bus.OUT_READY = 1'b0;
    send_half(16'h0001, 1'b0);
    send_half(16'h0002, 1'b0);
    @(negedge CLK);
    check("rs_result", 64'(bus.RESULT), 64'h00020001);
    step();
    bus.OUT_READY = 1'b1;
    step();
    check("rs_err_sticky", 64'(bus.ERR_DROP), 64'd1);

    // Asynchronous reset mid-operation (COUNT=1, FSM in HI).
    bus.OUT_READY = 1'b0;
    send_half(16'h0011, 1'b0);
    send_half(16'h0022, 1'b0);
    send_half(16'h0033, 1'b0);
    check("ar_pre_count", 64'(bus.COUNT), 64'd1);
    #2;
    RST = 1'b1;
    #1;
    check("ar_out_valid", 64'(bus.OUT_VALID), 64'd0);
    check("ar_count",     64'(bus.COUNT),     64'd0);
    check("ar_err_drop",  64'(bus.ERR_DROP),  64'd0);
    step();
    RST = 1'b0;
    bus.OUT_READY = 1'b1;
    send_half(16'h0003, 1'b0);
    send_half(16'h0004, 1'b1);
    @(negedge CLK);
    check("ar_result", 64'(bus.RESULT), 64'h00040003);
    check("ar_c_out",  64'(bus.C_OUT),  64'd1);
    step();
    @(negedge CLK);
    check("ar_drained", 64'(bus.COUNT), 64'd0);
    step();

    // Wrap-around: 10 pairs with OUT_READY toggling every cycle.
    fork
      begin
        for (int p = 0; p < 10; p++) begin
          send_half(16'h1000 + 16'(p), 1'b0);
          send_half(16'h2000 + 16'(p), p[0]);
        end
      end
      begin
        int k;
        k = 0;
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 400 && k < 10; cyc++) begin
          @(negedge CLK);
          if (bus.OUT_VALID && bus.OUT_READY) begin
            check($sformatf("wrap_res%0d", k), 64'(bus.RESULT),
                  64'({16'h2000 + 16'(k), 16'h1000 + 16'(k)}));
            check($sformatf("wrap_c%0d", k), 64'(bus.C_OUT), 64'(k[0]));
            k++;
          end
          @(posedge CLK);
          #1;
          bus.OUT_READY = ~bus.OUT_READY;
        end
        if (k < 10) check("wrap_timeout", 64'(k), 64'd10);
      end
    join
    @(negedge CLK);
    check("wrap_drained", 64'(bus.COUNT), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_result_collector.md
Name: rca_result_collector

Overview:
- Receive end of the adder datapath: consumes the 16-bit registered sum stream and carry from the RCA wrapper.
- Each 32-bit add is emitted as two consecutive half-words, low half first. This block reassembles each pair into a 32-bit result plus carry.
- Results are buffered in a small FIFO and presented downstream on a valid/ready handshake.
- Applies backpressure upstream when the FIFO is full.

Parameters:
- HALF_W, 16, width of one incoming sum half-word; the result width is 2*HALF_W.
- DEPTH, 2, result FIFO depth in entries; must be a power of two and at least 2.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous active-high reset.
- S_IN  input  HALF_W  incoming sum half-word.
- C_IN  input  1  carry out of the adder; meaningful only on the high half-word.
- IN_VALID  input  1  S_IN/C_IN hold a valid half-word this cycle.
- IN_READY  output  1  collector accepts a half-word this cycle.
- RESYNC  input  1  discard any held low half and expect a low half next.
- RESULT  output  2*HALF_W  assembled sum, {high, low}.
- C_OUT  output  1  carry of the assembled result.
- OUT_VALID  output  1  RESULT/C_OUT valid.
- OUT_READY  input  1  downstream accepts the result.
- ERR_DROP  output  1  sticky flag: a held low half was discarded by RESYNC.
- COUNT  output  clog2(DEPTH)+1  number of FIFO entries occupied.

Behaviour:
- Reset (asynchronous, RST=1): FSM to LO, FIFO empty, COUNT=0, OUT_VALID=0, RESULT=0, C_OUT=0, ERR_DROP=0, low-half holding register=0. IN_READY is 1 immediately after reset is released.
- Input transfer: occurs on a CLK edge where IN_VALID=1 and IN_READY=1.
- FSM state LO (expecting low half):
  - IN_READY=1 in this state.
  - On a transfer: latch S_IN into the low holding register, ignore C_IN, go to HI.
- FSM state HI (expecting high half):
  - IN_READY = (COUNT < DEPTH) OR (OUT_VALID AND OUT_READY), i.e. a same-cycle pop frees a slot.
  - On a transfer: push {S_IN, low_hold} and C_IN into the FIFO, return to LO.
- RESYNC:
  - RESYNC=1 forces the next state to LO and blocks any input transfer that cycle; IN_READY is 0 while RESYNC=1.
  - If the FSM was in HI, ERR_DROP is set to 1. It stays set until reset.
  - RESYNC in LO has no effect apart from the blocked transfer.
- Output side (FIFO):
  - RESULT and C_OUT come from the FIFO head register. They are stable while OUT_VALID=1 and OUT_READY=0.
  - OUT_VALID = (COUNT != 0).
  - Pop occurs on an edge with OUT_VALID=1 and OUT_READY=1.
- Simultaneous push and pop:
  - Allowed when full and when empty.
  - Full: COUNT unchanged.
  - Empty: no pop can occur (OUT_VALID=0); the push lands and OUT_VALID rises on the next cycle.
- Latency: the high half accepted at edge N gives OUT_VALID=1 after edge N (visible in cycle N+1). There is no combinational path from S_IN to RESULT.
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. COUNT updates by +1, -1 or 0 per cycle.
- Reset mid-operation: a held low half and all FIFO contents are lost with no error flagged. ERR_DROP is cleared.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_LO, ST_HI).
  - Default HALF_W.
  - A clog2 helper function.
- One sub-module: rca_result_fifo, a parameterised synchronous FIFO.
  - Ports: push/pop, data in/out, count.
  - Asynchronous active-high reset.
- The collector top holds the FSM, the low holding register, RESYNC/ERR_DROP logic and the handshake glue.

Test Plan:
- Basic pair: S_IN=16'h5678 then 16'h1234 with C_IN=1, OUT_READY=1 -> next cycle RESULT=32'h12345678, C_OUT=1, OUT_VALID=1 for one cycle, COUNT back to 0.
- Backpressure: OUT_READY=0, send 3 pairs with DEPTH=2 -> COUNT=2, IN_READY=0 in HI after third low half, third high half held. Raise OUT_READY -> third result accepted the same cycle as the first pop; results emerge in order.
- Simultaneous push/pop at full: COUNT=2, high half and pop on the same edge -> COUNT stays 2, head advances, no data lost or duplicated.
- RESYNC in HI: low 16'hAAAA, then RESYNC=1 -> ERR_DROP=1, FSM in LO. Following pair 16'h0001/16'h0002 -> RESULT=32'h00020001.
- Async reset mid-operation: assert RST between cycle edges with COUNT=1 and FSM=HI -> OUT_VALID, COUNT and ERR_DROP go to 0 immediately without a clock edge. After release, the next half-word is treated as a low half.
- Wrap-around: stream 10 pairs with OUT_READY toggling 1/0 -> all 10 results are correct and in order across pointer wraps.
